// File: rtl/conv_stream_driver.sv
// Initiator side of the convolver streams: a host loads x/filter vectors, start streams them
// out on valid/ready masters and collects the CONV_N y results into a readable buffer.
module conv_stream_driver #(
    parameter int  DATA_N   = 8,
    parameter int  FILTER_N = 4,
    parameter int  XW       = 8,
    parameter int  YW       = 18,
    localparam int CONV_N   = DATA_N - FILTER_N + 1,
    localparam int AW       = $clog2(DATA_N),
    localparam int FAW      = $clog2(FILTER_N),
    localparam int RAW      = $clog2(CONV_N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ld_valid,
    input  logic                 ld_sel,
    input  logic [AW-1:0]        ld_addr,
    input  logic signed [XW-1:0] ld_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 m_valid_x,
    input  logic                 m_ready_x,
    output logic signed [XW-1:0] m_data_out_x,
    output logic                 m_valid_f,
    input  logic                 m_ready_f,
    output logic signed [XW-1:0] m_data_out_f,
    input  logic                 s_valid_y,
    output logic                 s_ready_y,
    input  logic signed [YW-1:0] s_data_in_y,
    input  logic [RAW-1:0]       rd_addr,
    output logic signed [YW-1:0] rd_data
);
    localparam int XCW = $clog2(DATA_N + 1);
    localparam int FCW = $clog2(FILTER_N + 1);
    localparam int YCW = $clog2(CONV_N + 1);
    localparam logic [XCW-1:0] X_LAST = XCW'(DATA_N);
    localparam logic [FCW-1:0] F_LAST = FCW'(FILTER_N);
    localparam logic [YCW-1:0] Y_LAST = YCW'(CONV_N);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [XCW-1:0]        x_cnt_q, x_cnt_d, x_inc;
    logic [FCW-1:0]        f_cnt_q, f_cnt_d, f_inc;
    logic [YCW-1:0]        y_cnt_q, y_cnt_d, y_inc;
    logic                  x_vld_q, x_vld_d, f_vld_q, f_vld_d;
    logic signed [XW-1:0]  x_dat_q, x_dat_d, f_dat_q, f_dat_d;
    logic signed [XW-1:0]  x_buf_q [DATA_N];
    logic signed [XW-1:0]  f_buf_q [FILTER_N];
    logic signed [YW-1:0]  res_q   [CONV_N];
    logic                  ld_we, y_take;

    assign x_inc  = x_cnt_q + 1'b1;
    assign f_inc  = f_cnt_q + 1'b1;
    assign y_inc  = y_cnt_q + 1'b1;
    assign ld_we  = (state_q == IDLE) && ld_valid;
    assign y_take = s_ready_y && s_valid_y;

    assign busy         = (state_q == RUN);
    assign done         = (state_q == DONE);
    assign s_ready_y    = (state_q == RUN) && (y_cnt_q < Y_LAST);
    assign m_valid_x    = x_vld_q;
    assign m_valid_f    = f_vld_q;
    assign m_data_out_x = x_dat_q;
    assign m_data_out_f = f_dat_q;
    assign rd_data      = (int'(rd_addr) < CONV_N) ? res_q[rd_addr] : '0;

    always_comb begin
        state_d = state_q;
        x_cnt_d = x_cnt_q;
        f_cnt_d = f_cnt_q;
        y_cnt_d = y_cnt_q;
        x_vld_d = x_vld_q;
        f_vld_d = f_vld_q;
        x_dat_d = x_dat_q;
        f_dat_d = f_dat_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    x_cnt_d = '0;
                    f_cnt_d = '0;
                    y_cnt_d = '0;
                end
            end
            RUN: begin
                if (x_cnt_q == X_LAST && f_cnt_q == F_LAST && y_cnt_q == Y_LAST)
                    state_d = DONE;
                // On a transfer the next word is preloaded so a held-high ready sees no bubble.
                if (x_vld_q) begin
                    if (m_ready_x) begin
                        x_cnt_d = x_inc;
                        if (x_inc < X_LAST) x_dat_d = x_buf_q[x_inc[AW-1:0]];
                        else                x_vld_d = 1'b0;
                    end
                end else if (x_cnt_q < X_LAST) begin
                    x_vld_d = 1'b1;
                    x_dat_d = x_buf_q[x_cnt_q[AW-1:0]];
                end
                if (f_vld_q) begin
                    if (m_ready_f) begin
                        f_cnt_d = f_inc;
                        if (f_inc < F_LAST) f_dat_d = f_buf_q[f_inc[FAW-1:0]];
                        else                f_vld_d = 1'b0;
                    end
                end else if (f_cnt_q < F_LAST) begin
                    f_vld_d = 1'b1;
                    f_dat_d = f_buf_q[f_cnt_q[FAW-1:0]];
                end
                if (y_take) y_cnt_d = y_inc;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            x_cnt_q <= '0;
            f_cnt_q <= '0;
            y_cnt_q <= '0;
            x_vld_q <= 1'b0;
            f_vld_q <= 1'b0;
            x_dat_q <= '0;
            f_dat_q <= '0;
        end else begin
            state_q <= state_d;
            x_cnt_q <= x_cnt_d;
            f_cnt_q <= f_cnt_d;
            y_cnt_q <= y_cnt_d;
            x_vld_q <= x_vld_d;
            f_vld_q <= f_vld_d;
            x_dat_q <= x_dat_d;
            f_dat_q <= f_dat_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DATA_N; gi++) begin : g_xbuf
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)                                          x_buf_q[gi] <= '0;
                else if (ld_we && !ld_sel && ld_addr == AW'(gi))     x_buf_q[gi] <= ld_data;
            end
        end
        // Filter writes decode only the low address bits.
        for (gi = 0; gi < FILTER_N; gi++) begin : g_fbuf
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)                                          f_buf_q[gi] <= '0;
                else if (ld_we && ld_sel && ld_addr[FAW-1:0] == FAW'(gi)) f_buf_q[gi] <= ld_data;
            end
        end
        for (gi = 0; gi < CONV_N; gi++) begin : g_res
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)                                          res_q[gi] <= '0;
                else if (y_take && y_cnt_q == YCW'(gi))              res_q[gi] <= s_data_in_y;
            end
        end
    endgenerate
endmodule

// File: tb/tb_conv_stream_driver.sv
// Scoreboard bench for conv_stream_driver: expected stream beats and job lengths are queued at
// job issue and popped by a negedge monitor; the bench itself plays the y-returning convolver.
module tb_conv_stream_driver;
    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                ld_valid = 1'b0;
    logic                ld_sel = 1'b0;
    logic [2:0]          ld_addr = '0;
    logic signed [7:0]   ld_data = '0;
    logic                start = 1'b0;
    logic                busy, done;
    logic                m_valid_x, m_valid_f, s_ready_y;
    logic                m_ready_x = 1'b1;
    logic                m_ready_f = 1'b1;
    logic signed [7:0]   m_data_out_x, m_data_out_f;
    logic                s_valid_y = 1'b0;
    logic signed [17:0]  s_data_in_y = '0;
    logic [2:0]          rd_addr = '0;
    logic signed [17:0]  rd_data;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  n_done  = 0;
    int  busy_cnt = 0;
    int  exp_x[$], exp_f[$], exp_busy[$], y_src[$];
    bit  tog_en = 1'b0;
    logic                prev_vx = 1'b0, prev_rx = 1'b0;
    logic signed [7:0]   prev_dx = '0;

    conv_stream_driver dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .busy(busy), .done(done),
        .m_valid_x(m_valid_x), .m_ready_x(m_ready_x), .m_data_out_x(m_data_out_x),
        .m_valid_f(m_valid_f), .m_ready_f(m_ready_f), .m_data_out_f(m_data_out_f),
        .s_valid_y(s_valid_y), .s_ready_y(s_ready_y), .s_data_in_y(s_data_in_y),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end else
            $display("[TB] ok   %s = %0d", nm, act);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Monitor: stream beats, stall stability, done pulses and busy length.
    always @(negedge clk) begin
        if (!reset) begin
            busy_cnt = 0;
            prev_vx  = 1'b0;
            prev_rx  = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (exp_busy.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    int e;
                    e = exp_busy.pop_front();
                    if (e >= 0) chk("busy_len", busy_cnt, e);
                    n_done++;
                end
                busy_cnt = 0;
            end
            if (prev_vx && !prev_rx) begin
                chk("x_stall_valid", int'(m_valid_x), 1);
                chk("x_stall_data", int'(m_data_out_x), int'(prev_dx));
            end
            if (m_valid_x && m_ready_x) begin
                if (exp_x.size() == 0) chk("x_extra_beat", int'(m_data_out_x), -999);
                else                   chk("x_beat", int'(m_data_out_x), exp_x.pop_front());
            end
            if (m_valid_f && m_ready_f) begin
                if (exp_f.size() == 0) chk("f_extra_beat", int'(m_data_out_f), -999);
                else                   chk("f_beat", int'(m_data_out_f), exp_f.pop_front());
            end
            prev_vx = m_valid_x;
            prev_rx = m_ready_x;
            prev_dx = m_data_out_x;
        end
    end

    // y source: presents the head of y_src, retires it after an accepted beat.
    initial begin
        bit fire;
        forever begin
            @(negedge clk);
            fire = s_valid_y && s_ready_y && reset;
            @(posedge clk); #1;
            if (fire && y_src.size() > 0) void'(y_src.pop_front());
            if (y_src.size() > 0) begin
                s_valid_y   = 1'b1;
                s_data_in_y = 18'(y_src[0]);
            end else begin
                s_valid_y   = 1'b0;
                s_data_in_y = '0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        m_ready_x = tog_en ? !m_ready_x : 1'b1;
    end

    task automatic load(input bit sel, input int addr, input int d);
        ld_valid = 1'b1; ld_sel = sel; ld_addr = 3'(addr); ld_data = 8'(d);
        step();
        ld_valid = 1'b0;
    endtask

    task automatic push_job(input int xs[8], input int fs[4], input int bl);
        foreach (xs[i]) exp_x.push_back(xs[i]);
        foreach (fs[i]) exp_f.push_back(fs[i]);
        exp_busy.push_back(bl);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int d0 = n_done;
        int k  = 0;
        while (n_done == d0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_done_seen"}, (n_done > d0) ? 1 : 0, 1);
        step();
        chk({nm, "_streams_drained"}, exp_x.size() + exp_f.size(), 0);
    endtask

    task automatic chk_res(input string nm, input int e[5]);
        for (int i = 0; i < 5; i++) begin
            rd_addr = 3'(i);
            #1;
            chk($sformatf("%s[%0d]", nm, i), int'(rd_data), e[i]);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_busy"},    int'(busy), 0);
        chk({nm, "_done"},    int'(done), 0);
        chk({nm, "_vx"},      int'(m_valid_x), 0);
        chk({nm, "_vf"},      int'(m_valid_f), 0);
        chk({nm, "_ready_y"}, int'(s_ready_y), 0);
        chk({nm, "_dx"},      int'(m_data_out_x), 0);
        chk({nm, "_df"},      int'(m_data_out_f), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int xs[8], fs[4], xz[8], fz[4], xm[8], fm[4];
        bit found;
        xs = '{1, 2, 3, 4, 5, 6, 7, 8};
        fs = '{1, 1, 1, 1};
        xz = '{0, 0, 0, 0, 0, 0, 0, 0};
        fz = '{0, 0, 0, 0};
        xm = '{-128, -128, -128, -128, -128, -128, -128, -128};
        fm = '{-128, -128, -128, -128};

        repeat (3) @(posedge clk);
        #1;
        chk_idle("rst");
        chk_res("rst_res", '{0, 0, 0, 0, 0});
        reset = 1'b1;
        step();

        // Basic job; x[7] is written in the same cycle as start.
        for (int i = 0; i < 7; i++) load(1'b0, i, i + 1);
        for (int i = 0; i < 4; i++) load(1'b1, i, 1);
        push_job(xs, fs, 10);
        y_src = '{10, 14, 18, 22, 26};
        ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 3'd7; ld_data = 8'sd8;
        pulse_start();
        ld_valid = 1'b0;
        wait_done("t1");
        chk_res("t1_res", '{10, 14, 18, 22, 26});

        // Same job with x ready toggling.
        tog_en = 1'b1;
        push_job(xs, fs, -1);
        y_src = '{10, 14, 18, 22, 26};
        pulse_start();
        wait_done("t2");
        tog_en = 1'b0;
        chk_res("t2_res", '{10, 14, 18, 22, 26});

        // Reset during the third x beat.
        push_job(xs, fs, 10);
        y_src = '{10, 14, 18, 22, 26};
        pulse_start();
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (m_valid_x && m_data_out_x == 8'sd3) found = 1'b1;
        end
        chk("t4_third_beat_seen", int'(found), 1);
        #2;
        reset = 1'b0;
        exp_x.delete(); exp_f.delete(); exp_busy.delete(); y_src.delete();
        #1;
        chk_idle("t4");
        chk_res("t4_res", '{0, 0, 0, 0, 0});
        step();
        reset = 1'b1;
        step();

        // Unloaded job after reset streams cleared buffers.
        push_job(xz, fz, 10);
        y_src = '{0, 0, 0, 0, 0};
        pulse_start();
        wait_done("t4z");

        // Extreme negative operands.
        for (int i = 0; i < 8; i++) load(1'b0, i, -128);
        for (int i = 0; i < 4; i++) load(1'b1, i, -128);
        push_job(xm, fm, 10);
        y_src = '{65536, 65536, 65536, 65536, 65536};
        pulse_start();
        wait_done("t3");
        chk_res("t3_res", '{65536, 65536, 65536, 65536, 65536});
        rd_addr = 3'd2;
        #1;
        chk("t3_msb", int'(rd_data[17]), 0);
        chk("t3_bit16", int'(rd_data[16]), 1);
        step();

        // start and host writes during RUN are ignored.
        push_job(xm, fm, 10);
        y_src = '{100, 200, 300, 400, 500};
        pulse_start();
        step();
        step();
        start = 1'b1; ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 3'd0; ld_data = 8'sd55;
        step();
        start = 1'b0; ld_sel = 1'b1; ld_addr = 3'd1; ld_data = 8'sd7;
        step();
        ld_valid = 1'b0;
        wait_done("t5");
        chk_res("t5_res", '{100, 200, 300, 400, 500});
        repeat (3) step();
        chk("t5_no_restart", int'(busy), 0);

        // Six y beats offered: only five accepted; buffers resend unchanged.
        push_job(xm, fm, 10);
        y_src = '{-5, -6, -7, -8, -9, -10};
        pulse_start();
        repeat (6) step();
        chk("t6_busy_mid", int'(busy), 1);
        chk("t6_ready_after5", int'(s_ready_y), 0);
        chk("t6_valid_pending", int'(s_valid_y), 1);
        wait_done("t6");
        chk("t6_y_left", y_src.size(), 1);
        chk_res("t6_res", '{-5, -6, -7, -8, -9});
        repeat (3) step();
        chk_res("t6_res_idle", '{-5, -6, -7, -8, -9});
        y_src.delete();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/conv_stream_driver.md
Name: conv_stream_driver

Overview:
- Initiator side of the convolver's stream interfaces: holds an x vector and a filter vector loaded by a host over a simple write port.
- On start, transmits them on valid/ready master streams (x and f) and collects the CONV_N results on a valid/ready slave stream (y) into a result buffer.
- Sits between host/bench control logic and an 8x4 convolver instance; the pair forms a self-contained convolution job engine.

Parameters:
- DATA_N, 8, x vector length
- FILTER_N, 4, filter length
- CONV_N, DATA_N-FILTER_N+1, number of y results (derived, not overridable)
- XW, 8, signed x/f sample width
- YW, 18, signed y result width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ld_valid  in  1  host write strobe
- ld_sel  in  1  0 = write x buffer, 1 = write f buffer
- ld_addr  in  clog2(DATA_N)  write index (f uses low clog2(FILTER_N) bits)
- ld_data  in  XW  signed write data
- start  in  1  single-cycle job start request
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job completion
- m_valid_x  out  1  x stream valid
- m_ready_x  in  1  x stream ready
- m_data_out_x  out  XW  x stream data, signed
- m_valid_f  out  1  f stream valid
- m_ready_f  in  1  f stream ready
- m_data_out_f  out  XW  f stream data, signed
- s_valid_y  in  1  y stream valid
- s_ready_y  out  1  y stream ready
- s_data_in_y  in  YW  y stream data, signed
- rd_addr  in  clog2(CONV_N)  result read index
- rd_data  out  YW  result buffer word at rd_addr, combinational

Behaviour:
- Reset (asserted low, async): state IDLE; busy=0, done=0, m_valid_x=0, m_valid_f=0, s_ready_y=0, all counters 0, x/f/result buffers cleared to 0, data outputs 0.
- FSM states:
  - IDLE: host writes accepted (ld_valid writes buffer[ld_sel][ld_addr] at the clock edge). start -> RUN next cycle; busy=1 from the cycle after start.
  - RUN: x and f streams progress independently, each with its own counter. A transfer occurs on any cycle where valid&&ready. Data index k comes from buffer[k]. m_valid_* deasserts the cycle after its last beat (DATA_N for x, FILTER_N for f). s_ready_y=1 throughout RUN until CONV_N beats are received; each y beat is written to result[y_cnt]. Exit to DONE when x_cnt==DATA_N, f_cnt==FILTER_N and y_cnt==CONV_N; y beats may arrive before the x/f streams finish.
  - DONE: one cycle; done=1, busy=0 next cycle, state -> IDLE.
- Handshake rules:
  - Valid is registered and never depends combinationally on ready.
  - Once valid is asserted, data is held stable and valid stays high until the transfer completes.
  - First x/f beat: valid rises the cycle after entering RUN.
  - With ready held high, one beat per cycle, no bubbles.
- Latency: with all readies high and y returned instantly, busy lasts max(DATA_N, FILTER_N, y arrival) + 2 cycles.
- Boundaries:
  - ld_valid while busy: ignored, buffers unchanged.
  - start while busy or in DONE: ignored.
  - start and ld_valid in the same IDLE cycle: the write is applied and the job uses the new value (write and start share the edge; first beat is read a cycle later).
  - s_valid_y when s_ready_y=0 (IDLE, or after CONV_N beats): no capture, no error.
  - Reset mid-job: immediate return to reset values; a partial stream is abandoned.
  - Buffers persist across jobs, so a re-start without reloading resends the same data.
- rd_data reads the result buffer at any time, including during RUN (partial results visible).

Test Plan:
- Load x=1..8, f=1,1,1,1; start; all readies high, y fed from a reference convolver -> result[0..4] = 10,14,18,22,26; done one pulse; busy high 10 cycles with instant y.
- Same job with m_ready_x toggling 1,0,1,0 -> m_data_out_x is stable during stalls, exactly 8 x beats occur in order 1..8, and results are unchanged.
- x all -128, f all -128 -> every result = 65536, and rd_data sign and width are correct.
- Assert reset low during the 3rd x beat -> all outputs return to reset values immediately, buffers read 0; a subsequent load and start completes normally.
- Pulse start and write ld_data during RUN -> job unaffected, no second done, buffers unchanged.
- Send 6 y beats with s_valid_y held high -> only 5 accepted (s_ready_y drops after the 5th), and result[4] holds the 5th value.
